// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding scoreboard:
// operand source encodings and the per-stage tag entry.
package fwd_pkg;

  localparam logic [1:0] SEL_RF = 2'd0;
  localparam logic [1:0] SEL_E  = 2'd1;
  localparam logic [1:0] SEL_M  = 2'd2;
  localparam logic [1:0] SEL_W  = 2'd3;

  // Tags hold destinations zero-extended to this width;
  // REG_AW of the scoreboard must not exceed it.
  localparam int unsigned TAG_AW = 8;

  typedef struct packed {
    logic              valid;
    logic [TAG_AW-1:0] dst;
    logic [1:0]        rdy_stg;
  } tag_t;

  // Register 0 is hard-wired, so it never matches.
  function automatic logic tag_hit(
    input tag_t              t,
    input logic [TAG_AW-1:0] a
  );
    return t.valid && (t.dst == a) && (a != '0);
  endfunction

endpackage

// File: rtl/fwd_port_sel.sv
// One read port: find the youngest in-flight writer of the
// source register, forward its result or request a stall.
module fwd_port_sel
  import fwd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  tag_t              tag_e,
  input  tag_t              tag_m,
  input  tag_t              tag_w,
  input  logic [REG_AW-1:0] rp_addr,
  input  logic [DATA_W-1:0] rf_data,
  input  logic [DATA_W-1:0] res_e,
  input  logic [DATA_W-1:0] res_m,
  input  logic [DATA_W-1:0] res_w,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] data,
  output logic              stall_req
);

  logic [TAG_AW-1:0] addr;
  logic              hit_e;
  logic              hit_m;
  logic              hit_w;

  assign addr  = TAG_AW'(rp_addr);
  assign hit_e = tag_hit(tag_e, addr);
  assign hit_m = tag_hit(tag_m, addr);
  assign hit_w = tag_hit(tag_w, addr);

  // Youngest match wins; stage numbers equal SEL codes,
  // so a result is ready once rdy_stg <= current stage.
  always_comb begin
    sel       = SEL_RF;
    data      = rf_data;
    stall_req = 1'b0;
    unique case (1'b1)
      hit_e: begin
        if (tag_e.rdy_stg <= SEL_E) begin
          sel  = SEL_E;
          data = res_e;
        end else begin
          stall_req = 1'b1;
        end
      end
      !hit_e && hit_m: begin
        if (tag_m.rdy_stg <= SEL_M) begin
          sel  = SEL_M;
          data = res_m;
        end else begin
          stall_req = 1'b1;
        end
      end
      !hit_e && !hit_m && hit_w: begin
        sel  = SEL_W;
        data = res_w;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// E/M/W destination-tag pipeline driving operand forwarding
// and load-use stalls. FWD_STALL_CNT_EN adds stall_cnt.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_RP = 2,
  parameter int REG_AW = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic                     id_wr_en,
  input  logic [REG_AW-1:0]        id_dst,
  input  logic [1:0]               id_rdy_stg,
  input  logic                     flush_e,
  input  logic [NUM_RP*REG_AW-1:0] rp_addr,
  input  logic [NUM_RP*DATA_W-1:0] rf_data,
  input  logic [DATA_W-1:0]        res_e,
  input  logic [DATA_W-1:0]        res_m,
  input  logic [DATA_W-1:0]        res_w,
  output logic                     stall_d,
  output logic [NUM_RP*2-1:0]      fwd_sel,
  output logic [NUM_RP*DATA_W-1:0] fwd_data
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [31:0]              stall_cnt
`endif
);

  tag_t e_q, e_d;
  tag_t m_q, m_d;
  tag_t w_q, w_d;

  logic [NUM_RP-1:0] stall_req;

  for (genvar p = 0; p < NUM_RP; p++) begin : g_port
    fwd_port_sel #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW)
    ) u_sel (
      .tag_e     (e_q),
      .tag_m     (m_q),
      .tag_w     (w_q),
      .rp_addr   (rp_addr[p*REG_AW +: REG_AW]),
      .rf_data   (rf_data[p*DATA_W +: DATA_W]),
      .res_e     (res_e),
      .res_m     (res_m),
      .res_w     (res_w),
      .sel       (fwd_sel[p*2 +: 2]),
      .data      (fwd_data[p*DATA_W +: DATA_W]),
      .stall_req (stall_req[p])
    );
  end

  assign stall_d = |stall_req;

  // Advance tags; a stalled or flushed slot enters E as a bubble.
  always_comb begin
    e_d.valid   = id_valid & id_wr_en & ~stall_d & ~flush_e;
    e_d.dst     = TAG_AW'(id_dst);
    e_d.rdy_stg = id_rdy_stg;
    m_d         = e_q;
    w_d         = m_q;
  end

  // Tag registers; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

`ifdef FWD_STALL_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  // Saturating count of stalled cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (stall_d && (cnt_q != '1)) cnt_d = cnt_q + 32'd1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign stall_cnt = cnt_q;
`else
`endif

endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning datapath width.
REQ-002 SHALL have parameter NUM_RP, default 2, meaning number of D-stage read ports.
REQ-003 SHALL have parameter REG_AW, default 5, meaning register address width.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port id_valid  input  1  a valid instruction occupies D this cycle.
REQ-007 SHALL have port id_wr_en  input  1  the D instruction writes a register.
REQ-008 SHALL have port id_dst  input  REG_AW  destination register of the D instruction.
REQ-009 SHALL have port id_rdy_stg  input  2  first stage whose result bus carries the D instruction's result: 1=E, 2=M, 3=W.
REQ-010 SHALL have port flush_e  input  1  kill the instruction entering E.
REQ-011 SHALL have port rp_addr  input  NUM_RP*REG_AW  source register per read port.
REQ-012 SHALL have port rf_data  input  NUM_RP*DATA_W  register-file read data per port.
REQ-013 SHALL have ports res_e, res_m, res_w  input  DATA_W each  result of the instruction currently in E, M, W.
REQ-014 SHALL have port stall_d  output  1  hold D/F, insert bubble into E.
REQ-015 SHALL have port fwd_sel  output  NUM_RP*2  per-port source: 0=RF, 1=E, 2=M, 3=W.
REQ-016 SHALL have port fwd_data  output  NUM_RP*DATA_W  per-port forwarded operand.

Function
REQ-017 SHALL hold a tag entry {valid, dst, rdy_stg} for each of stages E, M, W.
REQ-018 SHALL, each cycle, shift W<=M and M<=E, and load E with {1, id_dst, id_rdy_stg}, or with a bubble (valid=0) when stall_d, flush_e, !id_valid or !id_wr_en.
REQ-019 SHALL treat an entry as matching a port when valid=1, dst==rp_addr and rp_addr!=0; register 0 never matches.
REQ-020 SHALL select, per port, the youngest matching entry, with priority E > M > W.
REQ-021 SHALL drive, for that entry at stage s (E=1, M=2, W=3), fwd_sel=s and fwd_data=res_s when rdy_stg<=s.
REQ-022 SHALL drive fwd_sel=0 and fwd_data=rf_data when no entry matches.
REQ-023 SHALL assert stall_d when any port's youngest match has rdy_stg>s; that port then drives fwd_sel=0.
REQ-024 SHALL forward from W even though W writes the register file in the same cycle; the register file need not bypass internally.
REQ-025 SHALL compute stall_d, fwd_sel and fwd_data combinationally from the current tags and inputs, with zero-cycle latency.
REQ-026 SHALL treat stall_d and flush_e asserted together as a single bubble into E.
REQ-027 SHALL continue shifting M and W while stall_d is asserted, so that a stall always resolves within 2 cycles.

Reset
REQ-028 SHALL clear all three valid bits on reset; dst and rdy_stg are don't-care.
REQ-029 SHALL output stall_d=0, fwd_sel=0 and fwd_data=rf_data in the first cycle after reset.
REQ-030 SHALL, when reset is asserted mid-stall, clear the stall on the next cycle and discard all in-flight tags.

Configuration
REQ-031 SHALL, with FWD_STALL_CNT_EN defined, add output stall_cnt (32 bits): reset to 0, increment on each cycle with stall_d=1, saturate at 32'hFFFF_FFFF.
REQ-032 SHALL, without FWD_STALL_CNT_EN, have no stall_cnt port and no counter logic.

Structure
REQ-033 SHALL define in shared package fwd_pkg the constants SEL_RF=0, SEL_E=1, SEL_M=2, SEL_W=3 and the tag-entry typedef.
REQ-034 SHALL instantiate sub-module fwd_port_sel once per read port; it performs match, priority, stall-request and data-mux.

Verification
REQ-035 SHALL verify, after reset with rp_addr0=8, rf_data0=0x11: fwd_sel0=0, fwd_data0=0x11, stall_d=0.
REQ-036 SHALL verify ALU op (dst=8, rdy=M) issued, then rp_addr0=8: cycle+1 (E) stall_d=1; cycle+2 (M) fwd_sel0=2, data=res_m.
REQ-037 SHALL verify load (dst=9, rdy=W), then reader of $9: stall_d=1 for 2 cycles, then fwd_sel=3, data=res_w=0xDEAD_BEEF.
REQ-038 SHALL verify jal (dst=31, rdy=E), then reader of $31 next cycle: no stall, fwd_sel=1, data=res_e=PC+8.
REQ-039 SHALL verify writes to $5 in M and W, both rdy: fwd_sel=2 (youngest); rp_addr=0 with a dst=0 entry: fwd_sel=0.
REQ-040 SHALL verify load-use stall with flush_e=1 asserted: E stays bubble; with FWD_STALL_CNT_EN, stall_cnt=2 after the 2-cycle stall.
